// File: rtl/cam_bank_sequencer.sv
// Packs camera bytes into 32-bit words and writes them round-robin into a set
// of RAM banks. The CPU arms the capture and returns drained banks by pulsing a release bit.
module cam_bank_sequencer #(
  parameter int WORDS_PER_BANK = 512,
  parameter int NUM_BANKS      = 4
) (
  input  logic                                     PCLKI,
  input  logic                                     WBs_RST_i,
  input  logic                                     VSYNCI,
  input  logic                                     HREFI,
  input  logic [7:0]                               CAM_DAT,
  input  logic                                     arm_i,
  input  logic [NUM_BANKS-1:0]                     bank_release_i,
  output logic [NUM_BANKS-1:0]                     ram_we_o,
  output logic [((WORDS_PER_BANK > 1) ? $clog2(WORDS_PER_BANK) : 1)-1:0] ram_wa_o,
  output logic [31:0]                              ram_wd_o,
  output logic [NUM_BANKS-1:0]                     bank_full_o,
  output logic [((NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1)-1:0] cur_bank_o,
  output logic                                     overflow_o,
  output logic                                     frame_done_o,
  output logic [1:0]                               state_o
);

  localparam int AW = (WORDS_PER_BANK > 1) ? $clog2(WORDS_PER_BANK) : 1;
  localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS_PER_BANK - 1);
  localparam logic [BW-1:0] LAST_BANK = BW'(NUM_BANKS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, DROP = 2'd3} state_t;

  state_t               state_reg;
  logic                 arm_meta_reg;
  logic                 arm_sync_reg;
  logic                 vsync_reg;
  logic                 end_pending_reg;
  logic [1:0]           byte_cnt_reg;
  logic [23:0]          pack_reg;
  logic [NUM_BANKS-1:0] full_set;
  logic [NUM_BANKS-1:0] full_next;
  logic [NUM_BANKS-1:0] bank_sel;
  logic [BW-1:0]        next_bank;
  logic [31:0]          partial_word;
  logic                 wr_active;
  logic                 byte_valid;
  logic                 vsync_rise;
  logic                 vsync_fall;
  logic                 next_is_full;

  assign wr_active    = |ram_we_o;
  assign byte_valid   = VSYNCI & HREFI;
  assign vsync_rise   = VSYNCI & ~vsync_reg;
  assign vsync_fall   = ~VSYNCI & vsync_reg;
  assign bank_sel     = NUM_BANKS'(1) << cur_bank_o;
  assign next_bank    = (cur_bank_o == LAST_BANK) ? '0 : cur_bank_o + BW'(1);
  // With a single bank the bank we advance to is the one just filled.
  assign next_is_full = (next_bank == cur_bank_o) | bank_full_o[next_bank];
  assign state_o      = state_reg;

  // Set wins over release; releasing an empty bank is a no-op.
  generate
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_full
      assign full_set[gi]  = wr_active && (ram_wa_o == LAST_ADDR) && (cur_bank_o == BW'(gi));
      assign full_next[gi] = full_set[gi] | (bank_full_o[gi] & ~bank_release_i[gi]);
    end
  endgenerate

  // Left-justify a 1-3 byte remainder, zero in the unused low bytes.
  always_comb begin
    partial_word = 32'h0;
    case (byte_cnt_reg)
      2'd1:    partial_word = {pack_reg[7:0], 24'h0};
      2'd2:    partial_word = {pack_reg[15:0], 16'h0};
      default: partial_word = {pack_reg[23:0], 8'h0};
    endcase
  end

  always_ff @(posedge PCLKI or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      state_reg       <= IDLE;
      arm_meta_reg    <= 1'b0;
      arm_sync_reg    <= 1'b0;
      vsync_reg       <= 1'b0;
      end_pending_reg <= 1'b0;
      byte_cnt_reg    <= 2'd0;
      pack_reg        <= 24'h0;
      ram_we_o        <= '0;
      ram_wa_o        <= '0;
      ram_wd_o        <= 32'h0;
      bank_full_o     <= '0;
      cur_bank_o      <= '0;
      overflow_o      <= 1'b0;
      frame_done_o    <= 1'b0;
    end else begin
      arm_meta_reg <= arm_i;
      arm_sync_reg <= arm_meta_reg;
      vsync_reg    <= VSYNCI;
      bank_full_o  <= full_next;
      ram_we_o     <= '0;
      frame_done_o <= 1'b0;

      // Address/bank bookkeeping runs the cycle after each strobe.
      if (wr_active) begin
        if (ram_wa_o == LAST_ADDR) begin
          ram_wa_o   <= '0;
          cur_bank_o <= next_bank;
          if (next_is_full) begin
            overflow_o <= 1'b1;
            if (state_reg == CAPTURE && !end_pending_reg) state_reg <= DROP;
          end
        end else begin
          ram_wa_o <= ram_wa_o + AW'(1);
        end
      end

      case (state_reg)
        IDLE: begin
          if (arm_sync_reg) state_reg <= ARMED;
        end
        ARMED: begin
          if (!arm_sync_reg) begin
            state_reg <= IDLE;
          end else if (vsync_rise) begin
            state_reg       <= CAPTURE;
            overflow_o      <= 1'b0;
            byte_cnt_reg    <= 2'd0;
            ram_wa_o        <= '0;
            end_pending_reg <= 1'b0;
          end
        end
        CAPTURE: begin
          if (end_pending_reg) begin
            end_pending_reg <= 1'b0;
            frame_done_o    <= 1'b1;
            state_reg       <= arm_sync_reg ? ARMED : IDLE;
          end else if (vsync_fall) begin
            byte_cnt_reg <= 2'd0;
            if (byte_cnt_reg != 2'd0) begin
              ram_wd_o        <= partial_word;
              ram_we_o        <= bank_sel;
              end_pending_reg <= 1'b1;
            end else begin
              frame_done_o <= 1'b1;
              state_reg    <= arm_sync_reg ? ARMED : IDLE;
            end
          end else if (byte_valid) begin
            pack_reg     <= {pack_reg[15:0], CAM_DAT};
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            if (byte_cnt_reg == 2'd3) begin
              ram_wd_o <= {pack_reg[23:0], CAM_DAT};
              ram_we_o <= bank_sel;
            end
          end
        end
        DROP: begin
          if (vsync_fall) begin
            frame_done_o <= 1'b1;
            state_reg    <= arm_sync_reg ? ARMED : IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_bank_sequencer.sv
// Directed frames into cam_bank_sequencer; expected RAM writes are queued by the
// stimulus side and matched by a monitor whenever a write strobe appears.
module tb_cam_bank_sequencer;

  logic        PCLKI = 1'b0;
  logic        WBs_RST_i = 1'b1;
  logic        VSYNCI = 1'b0;
  logic        HREFI = 1'b0;
  logic [7:0]  CAM_DAT = 8'h0;
  logic        arm_i = 1'b0;
  logic [3:0]  bank_release_i = 4'h0;
  logic [3:0]  ram_we_o;
  logic [8:0]  ram_wa_o;
  logic [31:0] ram_wd_o;
  logic [3:0]  bank_full_o;
  logic [1:0]  cur_bank_o;
  logic        overflow_o;
  logic        frame_done_o;
  logic [1:0]  state_o;

  cam_bank_sequencer #(.WORDS_PER_BANK(512), .NUM_BANKS(4)) dut (
    .PCLKI(PCLKI), .WBs_RST_i(WBs_RST_i), .VSYNCI(VSYNCI), .HREFI(HREFI),
    .CAM_DAT(CAM_DAT), .arm_i(arm_i), .bank_release_i(bank_release_i),
    .ram_we_o(ram_we_o), .ram_wa_o(ram_wa_o), .ram_wd_o(ram_wd_o),
    .bank_full_o(bank_full_o), .cur_bank_o(cur_bank_o), .overflow_o(overflow_o),
    .frame_done_o(frame_done_o), .state_o(state_o)
  );

  always #5 PCLKI = ~PCLKI;

  typedef struct packed {
    logic [1:0]  bank;
    logic [8:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t        exp_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         exp_bank = 0;
  int         exp_addr = 0;
  logic [3:0] exp_full = 4'h0;
  logic       exp_ovf = 1'b0;
  logic       exp_drop = 1'b0;
  logic [7:0] pb[4];
  int         pcnt = 0;
  int         exp_frames = 0;
  int         got_frames = 0;
  logic       rel_on_fill = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  // Reference behaviour of one word write: where it lands and what it does to the bank ring.
  task automatic model_write(input logic [31:0] w);
    wr_t e;
    e.bank = exp_bank[1:0];
    e.addr = exp_addr[8:0];
    e.data = w;
    exp_q.push_back(e);
    if (exp_addr == 511) begin
      exp_full[exp_bank] = 1'b1;
      exp_addr = 0;
      exp_bank = (exp_bank + 1) % 4;
      if (exp_full[exp_bank]) begin
        exp_ovf  = 1'b1;
        exp_drop = 1'b1;
      end
    end else begin
      exp_addr++;
    end
  endtask

  task automatic cyc(input logic vs, input logic hr, input logic [7:0] d, input logic [3:0] rel);
    @(negedge PCLKI);
    bank_release_i = rel;
    if (rel_on_fill && ram_we_o[0] && ram_wa_o == 9'd511) bank_release_i[0] = 1'b1;
    VSYNCI  = vs;
    HREFI   = hr;
    CAM_DAT = d;
  endtask

  task automatic send_byte(input logic [7:0] b);
    cyc(1'b1, 1'b1, b, 4'h0);
    if (!exp_drop) begin
      pb[pcnt] = b;
      pcnt++;
      if (pcnt == 4) begin
        model_write({pb[0], pb[1], pb[2], pb[3]});
        pcnt = 0;
      end
    end
  endtask

  task automatic start_frame();
    exp_addr = 0;
    exp_drop = 1'b0;
    exp_ovf  = 1'b0;
    pcnt     = 0;
    cyc(1'b1, 1'b0, 8'h0, 4'h0);
    cyc(1'b1, 1'b0, 8'h0, 4'h0);
  endtask

  task automatic end_frame();
    cyc(1'b0, 1'b0, 8'h0, 4'h0);
    if (pcnt > 0 && !exp_drop) begin
      for (int i = pcnt; i < 4; i++) pb[i] = 8'h0;
      model_write({pb[0], pb[1], pb[2], pb[3]});
    end
    pcnt = 0;
    exp_frames++;
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 8'h0, 4'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(VSYNCI, 1'b0, 8'h0, 4'h0);
  endtask

  // Monitor: every strobe must match the oldest queued write.
  always @(negedge PCLKI) begin
    if (ram_we_o != 4'h0) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: we=%b wa=%0d wd=0x%08h required no write",
                 ram_we_o, ram_wa_o, ram_wd_o);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (ram_we_o !== (4'b0001 << e.bank) || ram_wa_o !== e.addr || ram_wd_o !== e.data) begin
          n_fail++;
          $display("FAIL ram_write: got we=%b wa=%0d wd=0x%08h required we=%b wa=%0d wd=0x%08h",
                   ram_we_o, ram_wa_o, ram_wd_o, 4'b0001 << e.bank, e.addr, e.data);
        end else begin
          $display("write bank=%0d wa=%0d wd=0x%08h", e.bank, e.addr, e.data);
        end
      end
    end
    if (frame_done_o) got_frames++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, 32'(state_o), 32'd0);
    check({tag, "_we"}, 32'(ram_we_o), 32'd0);
    check({tag, "_wa"}, 32'(ram_wa_o), 32'd0);
    check({tag, "_wd"}, ram_wd_o, 32'd0);
    check({tag, "_full"}, 32'(bank_full_o), 32'd0);
    check({tag, "_cur"}, 32'(cur_bank_o), 32'd0);
    check({tag, "_ovf"}, 32'(overflow_o), 32'd0);
    check({tag, "_fdone"}, 32'(frame_done_o), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge PCLKI);
    check_reset_outputs("por");
    WBs_RST_i = 1'b0;

    // Arm and wait out the synchronizer
    arm_i = 1'b1;
    idle(4);
    check("armed_state", 32'(state_o), 32'd1);

    // 8 bytes with HREFI dropping mid-word
    start_frame();
    check("capture_state", 32'(state_o), 32'd2);
    send_byte(8'h01); send_byte(8'h02);
    idle(2);
    for (int i = 3; i <= 8; i++) send_byte(8'(i));
    end_frame();
    check("frame8_state", 32'(state_o), 32'd1);
    check("frame8_done", 32'(got_frames), 32'(exp_frames));
    check("frame8_wa", 32'(ram_wa_o), 32'd2);

    // 6 bytes -> zero-padded second word
    start_frame();
    for (int i = 1; i <= 6; i++) send_byte(8'(i));
    end_frame();
    check("frame6_done", 32'(got_frames), 32'(exp_frames));

    // Fill bank 0 exactly, with a release colliding with the fill
    rel_on_fill = 1'b1;
    start_frame();
    for (int i = 0; i < 2048; i++) send_byte(8'(i));
    end_frame();
    rel_on_fill = 1'b0;
    check("fill0_full", 32'(bank_full_o), 32'(exp_full));
    check("fill0_cur", 32'(cur_bank_o), 32'd1);
    check("fill0_wa", 32'(ram_wa_o), 32'd0);

    // Return bank 0; also release an empty bank
    cyc(1'b0, 1'b0, 8'h0, 4'b0101);
    exp_full[0] = 1'b0;
    idle(2);
    check("release_full", 32'(bank_full_o), 32'(exp_full));

    // Four banks plus one word with no releases -> overflow and drop
    start_frame();
    for (int i = 0; i < 4 * 2048 + 4; i++) send_byte(8'(i + 7));
    check("ovf_state", 32'(state_o), 32'd3);
    check("ovf_flag", 32'(overflow_o), 32'(exp_ovf));
    check("ovf_full", 32'(bank_full_o), 32'(exp_full));
    check("ovf_cur", 32'(cur_bank_o), 32'(exp_bank));
    end_frame();
    check("ovf_exit_state", 32'(state_o), 32'd1);
    check("ovf_sticky", 32'(overflow_o), 32'd1);
    check("ovf_done", 32'(got_frames), 32'(exp_frames));

    // Next entry clears overflow; disarm mid-frame takes effect at frame end
    start_frame();
    check("reentry_ovf", 32'(overflow_o), 32'd0);
    arm_i = 1'b0;
    idle(5);
    check("disarm_mid_state", 32'(state_o), 32'd2);
    end_frame();
    check("disarm_end_state", 32'(state_o), 32'd0);
    check("disarm_done", 32'(got_frames), 32'(exp_frames));

    // Reset after 3 bytes mid-frame
    arm_i = 1'b1;
    idle(4);
    start_frame();
    for (int i = 1; i <= 3; i++) send_byte(8'(i + 8'h30));
    @(negedge PCLKI);
    WBs_RST_i = 1'b1;
    exp_bank = 0; exp_addr = 0; exp_full = 4'h0; exp_ovf = 1'b0; pcnt = 0;
    #1;
    check_reset_outputs("midrst");
    repeat (3) @(negedge PCLKI);
    WBs_RST_i = 1'b0;
    idle(8);
    VSYNCI = 1'b0;
    idle(4);
    check("post_rst_state", 32'(state_o), 32'd1);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("frames_total", 32'(got_frames), 32'(exp_frames));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cam_bank_sequencer.md
CAM_BANK_SEQUENCER -- requirements
Module: cam_bank_sequencer

Interface
REQ-001 SHALL have parameter WORDS_PER_BANK, default 512: 32-bit words per RAM bank (power of two).
REQ-002 SHALL have parameter NUM_BANKS, default 4: RAM banks filled in rotation (power of two).
REQ-003 SHALL have port PCLKI  in  1  camera pixel clock; all logic on its rising edge.
REQ-004 SHALL have port WBs_RST_i  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port VSYNCI  in  1  frame valid, high during active frame.
REQ-006 SHALL have port HREFI  in  1  line valid; a byte is valid when VSYNCI&HREFI.
REQ-007 SHALL have port CAM_DAT  in  8  pixel byte.
REQ-008 SHALL have port arm_i  in  1  capture enable from CPU status register, asynchronous; synchronized internally with 2 flops.
REQ-009 SHALL have port bank_release_i  in  NUM_BANKS  one-cycle PCLKI-domain pulses; bit k returns bank k to the writer.
REQ-010 SHALL have port ram_we_o  in/out: out  NUM_BANKS  one-hot write strobe per bank.
REQ-011 SHALL have port ram_wa_o  out  log2(WORDS_PER_BANK)  write word address.
REQ-012 SHALL have port ram_wd_o  out  32  write data.
REQ-013 SHALL have ports bank_full_o  out  NUM_BANKS  bank holds unread data; cur_bank_o  out  log2(NUM_BANKS)  bank being written; overflow_o  out  1  sticky data-loss flag; frame_done_o  out  1  one-cycle end-of-frame pulse; state_o  out  2  FSM state.

Function
REQ-014 SHALL implement states IDLE=0, ARMED=1, CAPTURE=2, DROP=3, encoded on state_o.
REQ-015 IDLE->ARMED when synchronized arm high; ARMED->IDLE when it goes low.
REQ-016 ARMED->CAPTURE on VSYNCI rising edge (registered VSYNCI 0, current 1); entry clears overflow_o, byte counter and ram_wa_o; cur_bank_o keeps its value.
REQ-017 In CAPTURE each valid byte SHALL shift into a packing register; first byte of a word lands in bits 31:24, fourth in 7:0.
REQ-018 On the fourth byte, the next cycle SHALL drive ram_wd_o with the packed word, ram_we_o[cur_bank_o]=1 for exactly one cycle, ram_wa_o at current word address; ram_wa_o increments the cycle after the strobe.
REQ-019 Write at address WORDS_PER_BANK-1 SHALL set bank_full_o[cur_bank_o], wrap ram_wa_o to 0 and advance cur_bank_o modulo NUM_BANKS.
REQ-020 If the bank being advanced to is already full, SHALL set overflow_o and enter DROP; no ram_we_o in DROP.
REQ-021 VSYNCI falling in CAPTURE: a partial word (1-3 bytes) SHALL be written zero-padded in low bytes; then frame_done_o pulses one cycle and state goes to ARMED if arm high, else IDLE.
REQ-022 VSYNCI falling in DROP SHALL pulse frame_done_o and exit as REQ-021 without writing.
REQ-023 arm deassertion during CAPTURE/DROP SHALL take effect only at frame end.
REQ-024 bank_release_i[k] SHALL clear bank_full_o[k] next cycle; release and set of the same bank in one cycle: set wins; release of a non-full bank ignored.
REQ-025 overflow_o SHALL stay set until next CAPTURE entry or reset.
REQ-026 Bytes with HREFI low or outside CAPTURE SHALL be ignored; HREFI toggling mid-word SHALL not reset the byte counter.

Reset
REQ-027 Reset SHALL force IDLE, ram_we_o=0, ram_wa_o=0, ram_wd_o=0, bank_full_o=0, cur_bank_o=0, overflow_o=0, frame_done_o=0, arm synchronizer=0.
REQ-028 Reset mid-CAPTURE SHALL abort immediately with no further write strobes; partial word discarded.

Verification
REQ-029 Arm, frame of 8 bytes 01..08 -> ram_we_o[0] twice, wa 0/1, wd 0x01020304 then 0x05060708, frame_done_o one pulse, state ARMED.
REQ-030 Frame of 6 bytes -> second word 0x05060000 written at VSYNCI fall.
REQ-031 2048 bytes (512 words) -> bank_full_o=0001, cur_bank_o=1, wa wraps to 0.
REQ-032 No releases, 4x2048+4 bytes -> bank_full_o=1111, overflow_o=1, state DROP, no fifth-bank write; next frame entry clears overflow_o.
REQ-033 bank_release_i[0] on same cycle bank 0 fills -> bank_full_o[0] remains 1.
REQ-034 Assert WBs_RST_i after 3 bytes mid-frame -> all outputs reset values, no ram_we_o pulse afterward.
